pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 116 +++++++++++
 tb/tb_pipe_adder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Purpose  : Chunked, carry-pipelined adder with valid/ready flow control.
//            Stage k adds chunk k of a and b plus the carry from stage k-1.
//            The operands move down the pipe with the partial sum so that
//            the upper chunks are still available to later stages.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_valid   - operand beat present
//            in_ready   - beat accepted this cycle when in_valid is high
//            a, b, cin  - operands and carry-in
//            out_valid  - result beat present
//            out_ready  - downstream takes the result this cycle
//            sum        - (a + b + cin) mod 2^WIDTH
//            cout       - carry out of bit WIDTH-1
//            ovf        - cout (unsigned) or signed overflow (SIGNED=1)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be an integer multiple of STAGES.
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             w_en;
  logic             w_cmsb;
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];

  // Whole pipe advances together; it only freezes when a result is
  // waiting and downstream refuses it.
  assign w_en     = !r_valid[LAST] || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_v_in;
    logic             w_c_in;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_s_in;
    logic [WIDTH-1:0] w_s_nxt;
    logic [CW:0]      w_part;

    if (k == 0) begin : g_head
      assign w_v_in = in_valid;
      assign w_c_in = cin;
      assign w_a_in = a;
      assign w_b_in = b;
      assign w_s_in = '0;
    end else begin : g_tail
      assign w_v_in = r_valid[k-1];
      assign w_c_in = r_carry[k-1];
      assign w_a_in = r_a[k-1];
      assign w_b_in = r_b[k-1];
      assign w_s_in = r_sum[k-1];
    end

    assign w_part = {1'b0, w_a_in[k*CW +: CW]}
                  + {1'b0, w_b_in[k*CW +: CW]}
                  + {{CW{1'b0}}, w_c_in};

    // Lower chunks come from earlier stages; this stage fills in chunk k.
    always_comb begin
      w_s_nxt              = w_s_in;
      w_s_nxt[k*CW +: CW]  = w_part[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid[k] <= 1'b0;
        r_carry[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
      end else if (w_en) begin
        r_valid[k] <= w_v_in;
        r_carry[k] <= w_part[CW];
        r_a[k]     <= w_a_in;
        r_b[k]     <= w_b_in;
        r_sum[k]   <= w_s_nxt;
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_carry[LAST];

  // Carry into the MSB recovered from the MSB's own full-adder equation,
  // so no extra carry needs to be pipelined.
  assign w_cmsb = r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ r_sum[LAST][WIDTH-1];
  assign ovf    = SIGNED ? (w_cmsb ^ r_carry[LAST]) : r_carry[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Purpose  : Self-checking bench for pipe_adder. Five instances share the
//            stimulus: STAGES=4 unsigned, STAGES=4 signed, and STAGES=1,2,8
//            unsigned. Each instance has its own expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;
    localparam int NDUT = 5;

    function automatic int st_of(input int idx);
        case (idx)
            0, 1:    return 4;
            2:       return 1;
            3:       return 2;
            default: return 8;
        endcase
    endfunction

    // Reference result: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [32:0] op, input bit sgn);
        logic [15:0] ma, mb;
        logic [16:0] full;
        logic        v;
        ma   = op[32:17];
        mb   = op[16:1];
        full = {1'b0, ma} + {1'b0, mb} + {16'd0, op[0]};
        if (sgn) v = (ma[15] == mb[15]) && (full[15] != ma[15]);
        else     v = full[16];
        return {v, full[16], full[15:0]};
    endfunction

    logic        clk, rst_n, in_valid, out_ready, cin;
    logic [15:0] a, b;
    logic        o_rdy [NDUT];
    logic        o_val [NDUT];
    logic        o_cout[NDUT];
    logic        o_ovf [NDUT];
    logic [15:0] o_sum [NDUT];
    int          n_acc [NDUT];
    int          n_out [NDUT];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        pipe_adder #(.WIDTH(16), .STAGES(st_of(i)), .SIGNED(i == 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[i]),
            .a(a), .b(b), .cin(cin), .out_valid(o_val[i]), .out_ready(out_ready),
            .sum(o_sum[i]), .cout(o_cout[i]), .ovf(o_ovf[i])
        );

        logic [32:0] q [$];
        logic        held = 1'b0;
        logic [17:0] held_v;

        // Inputs change just after posedge, so at negedge everything that will
        // be seen by the next posedge is stable.
        always @(negedge clk) begin : p_mon
            logic [32:0] op;
            logic [17:0] ex;
            if (!rst_n) begin
                q.delete();
                held     = 1'b0;
                n_acc[i] = n_out[i];
            end else begin
                if (held) begin
                    chk($sformatf("dut%0d hold_valid", i), o_val[i], 1'b1);
                    chk($sformatf("dut%0d hold_data", i), {o_ovf[i], o_cout[i], o_sum[i]}, held_v);
                end
                if (o_val[i] && out_ready) begin
                    chk($sformatf("dut%0d stale_result", i), (q.size() != 0), 1'b1);
                    if (q.size() != 0) begin
                        op = q.pop_front();
                        ex = model(op, i == 1);
                        chk($sformatf("dut%0d sum", i), o_sum[i], ex[15:0]);
                        chk($sformatf("dut%0d cout", i), o_cout[i], ex[16]);
                        chk($sformatf("dut%0d ovf", i), o_ovf[i], ex[17]);
                        n_out[i]++;
                    end
                end
                held   = o_val[i] && !out_ready;
                held_v = {o_ovf[i], o_cout[i], o_sum[i]};
                if (in_valid && o_rdy[i]) begin
                    q.push_back({a, b, cin});
                    n_acc[i]++;
                end
            end
        end
    end

    // One beat into an empty pipe; checks latency of every instance and the
    // exact values from the 4-stage unsigned and signed instances.
    task automatic send_one(input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic tc, input logic [15:0] es,
                            input logic ec, input logic eu, input logic esg);
        int          lat [NDUT];
        logic [15:0] s0;
        logic        c0, v0, v1;
        s0 = 'x; c0 = 'x; v0 = 'x; v1 = 'x;
        for (int k = 0; k < NDUT; k++) lat[k] = 0;
        @(posedge clk); #1;
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (lat[k] == 0 && o_val[k]) begin
                    lat[k] = c;
                    if (k == 0) begin s0 = o_sum[0]; c0 = o_cout[0]; v0 = o_ovf[0]; end
                    if (k == 1) v1 = o_ovf[1];
                end
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d latency", k), lat[k], st_of(k));
        end
        chk("vec_sum", s0, es);
        chk("vec_cout", c0, ec);
        chk("vec_ovf_unsigned", v0, eu);
        chk("vec_ovf_signed", v1, esg);
    endtask

    initial begin : p_stim
        int          sent, stallc, seen, out0;
        bit          rel, all;
        logic [15:0] hold_s;
        int          base [NDUT];

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        for (int k = 0; k < NDUT; k++) begin n_acc[k] = 0; n_out[k] = 0; end
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d rst_valid", k), o_val[k], 1'b0);
            chk($sformatf("dut%0d rst_sum", k), o_sum[k], 16'h0000);
            chk($sformatf("dut%0d rst_cout", k), o_cout[k], 1'b0);
            chk($sformatf("dut%0d rst_ovf", k), o_ovf[k], 1'b0);
        end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d ready_after_reset", k), o_rdy[k], 1'b1);
        end

        // Directed vectors: sum, cout, unsigned ovf, signed ovf.
        send_one(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        send_one(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        send_one(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        send_one(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        send_one(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Back-pressure: six beats into the 4-stage pipe with out_ready low.
        out0 = n_out[0]; sent = 0; stallc = 0; rel = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (rel) out_ready = 1'b1;
            in_valid = (sent < 6);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (in_valid && o_rdy[0]) sent++;
            if (!rel && o_val[0] && !out_ready) begin
                if (stallc == 0) hold_s = o_sum[0];
                stallc++;
                if (stallc == 4) begin
                    chk("bp_in_ready_low", o_rdy[0], 1'b0);
                    chk("bp_first_held", o_sum[0], hold_s);
                    rel = 1'b1;
                end
            end
            if (sent == 6 && rel) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("bp_results_out", n_out[0] - out0, 6);

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d midrst_valid", k), o_val[k], 1'b0);
            chk($sformatf("dut%0d midrst_out", k), {o_ovf[k], o_cout[k], o_sum[k]}, 18'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) if (o_val[k]) seen++;
        end
        chk("no_stale_after_reset", seen, 0);
        send_one(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);

        // Random traffic with random stalls on both sides.
        for (int k = 0; k < NDUT; k++) base[k] = n_acc[k];
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
            @(negedge clk);
            all = 1'b1;
            for (int k = 0; k < NDUT; k++) if (n_acc[k] - base[k] < 1000) all = 1'b0;
            if (all) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d rand_count", k), (n_acc[k] - base[k] >= 1000), 1'b1);
            chk($sformatf("dut%0d none_dropped", k), n_out[k], n_acc[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
